// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0004_0000;

  // Clears the two byte-offset bits of a word address.
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: circular buffer with explicit pointer wrap so any depth >= 2
// works; flush empties it in one cycle and wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  T                       i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output T                       o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointers and occupancy; a flush discards everything, including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is data only and needs no reset
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch queue: owns the PC, issues word reads to a 1-cycle synchronous
// instruction memory and buffers {instr, pc} pairs for decode. Reads are
// credited against FIFO space so the FIFO cannot overflow; an epoch bit tags
// each read so responses belonging to a flushed stream are dropped.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int              FIFO_DEPTH = 4,
  parameter int              PC_STEP    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_tag_pc;
  logic             r_tag_epoch;
  logic             r_epoch;
  logic             r_inflight;

  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  logic [XLEN-1:0]  w_redirect_aligned;
  entry_t           w_push_entry;
  entry_t           w_head;

  assign w_redirect_aligned = redirect_pc & ~XLEN'(~ALIGN_MASK);

  // Credit check uses the registered count, so a read is only issued when a
  // slot is guaranteed for its response; nothing issues while in reset.
  assign w_issue = rst && !redirect_valid && !w_full &&
                   ((int'(w_count) + int'(r_inflight)) < FIFO_DEPTH);

  assign w_push             = r_inflight && (r_tag_epoch == r_epoch);
  assign w_pop              = out_valid && out_ready;
  assign w_push_entry.instr = imem_rsp_data;
  assign w_push_entry.pc    = r_tag_pc;

  assign imem_req_valid = w_issue;
  assign imem_req_addr  = r_pc;
  assign out_valid      = (w_count != '0);
  assign out_instr      = out_valid ? w_head.instr : '0;
  assign out_pc         = out_valid ? w_head.pc    : '0;

  // PC, epoch and in-flight tracking; a redirect overrides sequential advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_epoch     <= 1'b0;
      r_inflight  <= 1'b0;
      r_tag_epoch <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_tag_epoch <= r_epoch;
      if (redirect_valid) begin
        r_pc    <= w_redirect_aligned;
        r_epoch <= ~r_epoch;
      end else if (w_issue) begin
        r_pc <= r_pc + XLEN'(PC_STEP);
      end
    end
  end

  // Request PC travels with the read so the response can be paired with it
  always_ff @(posedge clk) begin
    if (w_issue) r_tag_pc <= r_pc;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_full      (w_full),
    .o_count     (w_count),
    .o_head      (w_head)
  );

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-cycle fetch path. It owns the PC, issues word reads to a 1-cycle-latency synchronous instruction memory, and buffers returned instructions in a prefetch FIFO.
- Delivers {instruction, PC} pairs downstream over a valid/ready handshake.
- Supports branch redirect with flush and discard of in-flight reads.
- Sits between the instruction memory and decode.

Parameters:
XLEN, 32, PC and instruction width in bits
RESET_PC, 32'h0004_0000, PC value loaded on reset (program base address)
FIFO_DEPTH, 4, prefetch entries; legal >= 2, full throughput requires >= 3
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (forced to 0)
imem_req_valid  output  1  read request this cycle
imem_req_addr  output  XLEN  byte address of the read (word-aligned)
imem_rsp_data  input  XLEN  read data, valid exactly 1 cycle after imem_req_valid
out_valid  output  1  FIFO head holds a valid instruction
out_instr  output  XLEN  instruction at the FIFO head
out_pc  output  XLEN  PC of out_instr
out_ready  input  1  downstream accepts the head this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_q=RESET_PC, FIFO empty, count=0, inflight=0, epoch=0.
  - out_valid=0, imem_req_valid=0, out_instr=0, out_pc=0, imem_req_addr=RESET_PC.
  - Reset mid-operation drops all FIFO contents and in-flight reads. A response arriving in the cycle after rst deasserts is ignored.
- Issue:
  - imem_req_valid = !redirect_valid && (count + inflight) < FIFO_DEPTH.
  - imem_req_addr = pc_q. On issue, pc_q <= pc_q + PC_STEP, modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
  - The issue check uses the registered count, not count after this cycle's pop. This credit scheme makes FIFO overflow impossible.
- In-flight tracking:
  - inflight (1 bit) <= issue.
  - The tag register holds {req pc, epoch} from the issuing cycle.
- Response:
  - In the cycle after issue, imem_rsp_data is pushed together with the tagged pc, but only if tag epoch == current epoch.
  - A mismatched epoch means a stale response, which is discarded silently.
- Pop: out_valid && out_ready removes the head.
  - Push and pop in the same cycle: count unchanged; head advances and tail advances.
  - Empty FIFO with a response arriving: the entry appears at out_valid the next cycle. There is no combinational bypass; load-to-use latency from issue is 2 cycles.
- Handshake:
  - While out_valid && !out_ready, out_instr and out_pc hold stable.
  - out_valid never drops without a pop or a redirect.
- Redirect (redirect_valid=1):
  - At the clock edge: FIFO flushed (count=0), pc_q <= {redirect_pc[XLEN-1:2],2'b00}, epoch toggles.
  - No request is issued in the redirect cycle. The first request to the target is issued the next cycle, with out_valid 2 cycles after that request.
  - A pop in the same cycle as a redirect still counts as accepted downstream; the flush takes priority for FIFO state.
  - Back-to-back redirects: the last one wins; each toggles the epoch.
- Full: count == FIFO_DEPTH means no issue and out_valid=1. Issue resumes in the cycle after the first pop.
- Steady state with out_ready=1 and FIFO_DEPTH >= 3: one instruction per cycle, PCs consecutive with step PC_STEP.
- Pointers: log2(FIFO_DEPTH) bits wide; count is one bit wider. Non-power-of-two depth wraps explicitly at FIFO_DEPTH-1.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN and RESET_PC defaults;
  - fetch_entry_t {instr, pc};
  - the ALIGN_MASK constant.
- Sub-module fetch_fifo:
  - parametrised by depth and entry type;
  - ports push, pop, flush, full, count, head;
  - synchronous flush and asynchronous active-low reset.
- PC/credit/epoch logic lives in the top module.

Test Plan:
- Reset then release, out_ready=1, memory returns 32'h1000_0000+addr → out_pc sequence 0x40000, 0x40004, 0x40008…, one per cycle starting 3 cycles after release; out_instr matches.
- out_ready=0 for 10 cycles → exactly 4 requests issued, count=4, head pc=0x40000 held stable; after out_ready=1, issue resumes the next cycle with no lost or duplicated PCs.
- Redirect to 0x40103 (misaligned) while FIFO holds 3 entries and a read is in flight → flush; stale response dropped; next out_pc=0x40100, seen exactly 3 cycles after redirect.
- Redirect on two consecutive cycles (0x40200, then 0x40300) → only the 0x40300 stream appears; no 0x40200 entry is ever valid.
- Reset with RESET_PC=32'hFFFF_FFF8 and out_ready=1 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst low mid-stream with 2 entries plus 1 read in flight → out_valid=0 immediately (asynchronous); after release, the first out_pc equals RESET_PC.
